// File: rtl/tipi_sreg_bridge.sv
// tipi_sreg_bridge: TI <-> RPi framed shift-register exchange, single clk domain.
// Ports: clk/reset (async high); ti_wr/ti_wsel/ti_wdata write TI-origin regs;
//   ti_rsel/ti_rdata registered read of either bank; r_clk/r_le/r_rt/r_sel/r_dout
//   async RPi pins (synchronised); r_din serial to RPi; ti_pend, busy, frame_err.
// Optional: define TIPI_RX_PARITY_EN to drive the parity of the last committed
//   RX word on r_din while idle.
module tipi_sreg_bridge #(
  parameter int WIDTH = 8,
  parameter int NCH = 2,
  parameter int SYNC_STAGES = 2,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ti_wr,
  input  logic [IW-1:0]    ti_wsel,
  input  logic [WIDTH-1:0] ti_wdata,
  input  logic [IW:0]      ti_rsel,
  output logic [WIDTH-1:0] ti_rdata,
  input  logic             r_clk,
  input  logic             r_le,
  input  logic             r_rt,
  input  logic [IW-1:0]    r_sel,
  input  logic             r_dout,
  output logic             r_din,
  output logic [NCH-1:0]   ti_pend,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE,
    TX,
    RX
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] treg [NCH];
  logic [WIDTH-1:0] rreg [NCH];
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  logic [SYNC_STAGES-1:0] clk_sy;
  logic [SYNC_STAGES-1:0] le_sy;
  logic [SYNC_STAGES-1:0] rt_sy;
  logic [SYNC_STAGES-1:0] dout_sy;
  logic [IW-1:0]          sel_sy [SYNC_STAGES];
  logic                   clk_q;
  logic                   le_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sy  <= '0;
      le_sy   <= '0;
      rt_sy   <= '0;
      dout_sy <= '0;
      for (int i = 0; i < SYNC_STAGES; i++)
        sel_sy[i] <= '0;
      clk_q <= 1'b0;
      le_q  <= 1'b0;
    end else begin
      clk_sy  <= {clk_sy[SYNC_STAGES-2:0], r_clk};
      le_sy   <= {le_sy[SYNC_STAGES-2:0], r_le};
      rt_sy   <= {rt_sy[SYNC_STAGES-2:0], r_rt};
      dout_sy <= {dout_sy[SYNC_STAGES-2:0], r_dout};
      sel_sy[0] <= r_sel;
      for (int i = 1; i < SYNC_STAGES; i++)
        sel_sy[i] <= sel_sy[i-1];
      clk_q <= clk_sy[SYNC_STAGES-1];
      le_q  <= le_sy[SYNC_STAGES-1];
    end
  end

  logic          clk_s;
  logic          le_s;
  logic          rt_s;
  logic          dout_s;
  logic [IW-1:0] sel_s;
  logic          clk_rise;
  logic          le_rise;
  logic          sel_ok;
  logic          wsel_ok;

  assign clk_s    = clk_sy[SYNC_STAGES-1];
  assign le_s     = le_sy[SYNC_STAGES-1];
  assign rt_s     = rt_sy[SYNC_STAGES-1];
  assign dout_s   = dout_sy[SYNC_STAGES-1];
  assign sel_s    = sel_sy[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_q;
  assign le_rise  = le_s & ~le_q;
  assign sel_ok   = int'(sel_s) < NCH;
  assign wsel_ok  = int'(ti_wsel) < NCH;

  logic [WIDTH-1:0] tx_word;
  logic             load;
  logic             commit;
  logic             good;
  logic             bad;

  assign tx_word = sel_ok ? treg[sel_s] : '0;
  // le takes priority over a same-cycle r_clk edge
  assign load    = le_rise &&
                   ((state == IDLE && rt_s) || state == TX);
  assign commit  = le_rise && state == RX;
  assign good    = commit && cnt == CW'(WIDTH) && sel_ok;
  assign bad     = (commit && !good) ||
                   (le_rise && state == IDLE && !rt_s && cnt == '0);

  logic idle_din;
  logic commit_din;

`ifdef TIPI_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      par_bit <= 1'b0;
    else if (good)
      par_bit <= ^shreg;
    else if (bad)
      par_bit <= 1'b0;
  end

  assign idle_din   = par_bit;
  assign commit_din = ^shreg;
`else
  assign idle_din   = 1'b0;
  assign commit_din = 1'b0;
`endif

  logic [WIDTH-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (int'(ti_rsel[IW-1:0]) < NCH)
      rd_word = ti_rsel[IW] ? treg[ti_rsel[IW-1:0]]
                            : rreg[ti_rsel[IW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      ti_rdata  <= '0;
      r_din     <= 1'b0;
      ti_pend   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        treg[i] <= '0;
        rreg[i] <= '0;
      end
    end else begin
      ti_rdata <= rd_word;
      if (load) begin
        state <= TX;
        busy  <= 1'b1;
        shreg <= tx_word;
        cnt   <= '0;
        r_din <= tx_word[WIDTH-1];
        if (sel_ok)
          ti_pend[sel_s] <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bad) begin
              frame_err <= 1'b1;
              r_din     <= 1'b0;
            end else if (!le_rise && clk_rise && !rt_s) begin
              state <= RX;
              busy  <= 1'b1;
              shreg <= {shreg[WIDTH-2:0], dout_s};
              cnt   <= CW'(1);
              r_din <= 1'b0;
            end
          end
          TX: begin
            if (clk_rise) begin
              shreg <= {shreg[WIDTH-2:0], 1'b0};
              cnt   <= cnt + 1'b1;
              if (cnt == CW'(WIDTH - 1)) begin
                state <= IDLE;
                busy  <= 1'b0;
                r_din <= idle_din;
              end else begin
                r_din <= shreg[WIDTH-2];
              end
            end
          end
          RX: begin
            if (commit) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
              if (good) begin
                rreg[sel_s] <= shreg;
                frame_err   <= 1'b0;
                r_din       <= commit_din;
              end else begin
                frame_err <= 1'b1;
                r_din     <= 1'b0;
              end
            end else if (clk_rise) begin
              shreg <= {shreg[WIDTH-2:0], dout_s};
              if (cnt != CW'(WIDTH + 1))
                cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
      // A TI write lands after any same-cycle load, so its pending bit wins
      if (ti_wr && wsel_ok) begin
        treg[ti_wsel]    <= ti_wdata;
        ti_pend[ti_wsel] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tipi_sreg_bridge.sv
// tb_tipi_sreg_bridge: directed + randomized bench for tipi_sreg_bridge
// with a word-level reference model of both register banks and status flags.
module tb_tipi_sreg_bridge;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int S  = 2;
  localparam int IW = 1;
  localparam int HOLD = S + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          ti_wr;
  logic [IW-1:0] ti_wsel;
  logic [W-1:0]  ti_wdata;
  logic [IW:0]   ti_rsel;
  logic [W-1:0]  ti_rdata;
  logic          r_clk;
  logic          r_le;
  logic          r_rt;
  logic [IW-1:0] r_sel;
  logic          r_dout;
  logic          r_din;
  logic [N-1:0]  ti_pend;
  logic          busy;
  logic          frame_err;

  tipi_sreg_bridge #(
    .WIDTH(W),
    .NCH(N),
    .SYNC_STAGES(S)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ti_wr(ti_wr),
    .ti_wsel(ti_wsel),
    .ti_wdata(ti_wdata),
    .ti_rsel(ti_rsel),
    .ti_rdata(ti_rdata),
    .r_clk(r_clk),
    .r_le(r_le),
    .r_rt(r_rt),
    .r_sel(r_sel),
    .r_dout(r_dout),
    .r_din(r_din),
    .ti_pend(ti_pend),
    .busy(busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] treg_m [N];
  logic [W-1:0] rreg_m [N];
  logic [N-1:0] pend_m;
  logic         ferr_m;
  logic         par_m;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic idle_din_m();
`ifdef TIPI_RX_PARITY_EN
    return par_m;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      treg_m[i] = '0;
      rreg_m[i] = '0;
    end
    pend_m = '0;
    ferr_m = 1'b0;
    par_m  = 1'b0;
  endtask

  task automatic nclk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(int sel, logic [W-1:0] d);
    @(negedge clk);
    ti_wr    = 1'b1;
    ti_wsel  = sel[IW-1:0];
    ti_wdata = d;
    @(negedge clk);
    ti_wr = 1'b0;
    treg_m[sel] = d;
    pend_m[sel] = 1'b1;
  endtask

  task automatic rd_check(string tag, bit bank, int idx);
    logic [W-1:0] e;
    @(negedge clk);
    ti_rsel = {bank, idx[IW-1:0]};
    @(negedge clk);
    e = bank ? treg_m[idx] : rreg_m[idx];
    chk(tag, ti_rdata, e);
  endtask

  task automatic pulse_clk(bit d);
    @(negedge clk);
    r_dout = d;
    r_clk  = 1'b1;
    nclk(HOLD);
    r_clk = 1'b0;
    nclk(HOLD);
  endtask

  task automatic pulse_le(bit rt, int sel);
    @(negedge clk);
    r_rt  = rt;
    r_sel = sel[IW-1:0];
    r_le  = 1'b1;
    nclk(HOLD);
    r_le = 1'b0;
    nclk(HOLD);
  endtask

  // Serial word as seen on r_din: MSB first, one bit per r_clk rise
  task automatic tx_check(string tag, logic [W-1:0] word);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("%s_b%0d", tag, i), r_din, word[W-1-i]);
      pulse_clk(1'b0);
    end
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_din_end"}, r_din, idle_din_m());
  endtask

  task automatic tx_start(int sel);
    pulse_le(1'b1, sel);
    pend_m[sel] = 1'b0;
  endtask

  task automatic rx_frame(logic [15:0] word, int nb, int sel);
    @(negedge clk);
    r_rt = 1'b0;
    for (int i = 0; i < nb; i++)
      pulse_clk(word[nb-1-i]);
    pulse_le(1'b0, sel);
    if (nb == W && sel < N) begin
      rreg_m[sel] = word[W-1:0];
      ferr_m = 1'b0;
      par_m  = ^word[W-1:0];
    end else begin
      ferr_m = 1'b1;
      par_m  = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] old;
    int sel;

    reset    = 1'b1;
    ti_wr    = 1'b0;
    ti_wsel  = '0;
    ti_wdata = '0;
    ti_rsel  = '0;
    r_clk    = 1'b0;
    r_le     = 1'b0;
    r_rt     = 1'b0;
    r_sel    = '0;
    r_dout   = 1'b0;
    model_reset();
    nclk(3);
    chk("rst_rdata", ti_rdata, 0);
    chk("rst_din", r_din, 0);
    chk("rst_pend", ti_pend, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd_check($sformatf("rst_treg%0d", i), 1'b1, i);
      rd_check($sformatf("rst_rreg%0d", i), 1'b0, i);
    end

    wr(1, 8'hA5);
    chk("tx_pend_set", ti_pend, pend_m);
    tx_start(1);
    chk("tx_pend_clr", ti_pend, pend_m);
    chk("tx_busy", busy, 1'b1);
    tx_check("tx_a5", 8'hA5);

    rx_frame(16'h3C, W, 0);
    rd_check("rx_3c", 1'b0, 0);
    chk("rx_3c_ferr", frame_err, ferr_m);
    chk("rx_3c_din", r_din, idle_din_m());
    rx_frame(16'h07, W, 0);
    rd_check("rx_07", 1'b0, 0);
    chk("rx_07_din", r_din, idle_din_m());

    pulse_le(1'b0, 1);
    ferr_m = 1'b1;
    par_m  = 1'b0;
    chk("le_idle_ferr", frame_err, ferr_m);
    chk("le_idle_din", r_din, idle_din_m());
    rx_frame(16'($urandom_range(255)), W, 1);
    chk("good_clr_ferr", frame_err, ferr_m);
    rd_check("good_rreg1", 1'b0, 1);

    rx_frame(16'($urandom_range(31)), 5, 0);
    chk("short_ferr", frame_err, ferr_m);
    rd_check("short_rreg0", 1'b0, 0);
    rx_frame(16'($urandom_range(255)), W, 0);
    chk("short_recover", frame_err, ferr_m);
    rd_check("recover_rreg0", 1'b0, 0);

    rx_frame(16'($urandom_range(511)), W + 1, 1);
    chk("long_ferr", frame_err, ferr_m);
    chk("long_din", r_din, idle_din_m());
    rd_check("long_rreg1", 1'b0, 1);

    for (int k = 0; k < 6; k++) begin
      sel = int'($urandom_range(N - 1));
      w = W'($urandom);
      if ($urandom_range(1) == 1) begin
        wr(sel, w);
        wr(1 - sel, W'($urandom));
        chk($sformatf("rnd%0d_pend", k), ti_pend, pend_m);
        rd_check($sformatf("rnd%0d_treg", k), 1'b1, sel);
        tx_start(sel);
        chk($sformatf("rnd%0d_pend_ld", k), ti_pend, pend_m);
        tx_check($sformatf("rnd%0d_tx", k), treg_m[sel]);
      end else begin
        rx_frame({8'h00, w}, W, sel);
        chk($sformatf("rnd%0d_ferr", k), frame_err, ferr_m);
        chk($sformatf("rnd%0d_din", k), r_din, idle_din_m());
        rd_check($sformatf("rnd%0d_rreg0", k), 1'b0, 0);
        rd_check($sformatf("rnd%0d_rreg1", k), 1'b0, 1);
      end
    end

    wr(0, 8'h80 | W'($urandom_range(127)));
    @(negedge clk);
    r_rt  = 1'b1;
    r_sel = '0;
    r_le  = 1'b1;
    @(posedge clk);
    #1 chk("lat_e1", busy, 1'b0);
    @(posedge clk);
    #1 chk("lat_e2", busy, 1'b0);
    @(posedge clk);
    #1 chk("lat_e3", busy, 1'b1);
    chk("lat_din", r_din, 1'b1);
    pend_m[0] = 1'b0;
    @(negedge clk);
    r_le = 1'b0;
    nclk(HOLD);

    pulse_clk(1'b0);
    chk("pre_sim_b1", r_din, treg_m[0][W-2]);
    pulse_clk(1'b0);
    chk("pre_sim_b2", r_din, treg_m[0][W-3]);
    wr(1, W'($urandom));
    @(negedge clk);
    r_rt  = 1'b1;
    r_sel = 1'b1;
    r_le  = 1'b1;
    r_clk = 1'b1;
    nclk(HOLD);
    r_le  = 1'b0;
    r_clk = 1'b0;
    nclk(HOLD);
    pend_m[1] = 1'b0;
    chk("sim_pend", ti_pend, pend_m);
    tx_check("sim", treg_m[1]);

    old = W'($urandom);
    w   = ~old;
    wr(0, old);
    @(negedge clk);
    r_rt  = 1'b1;
    r_sel = '0;
    r_le  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ti_wr    = 1'b1;
    ti_wsel  = '0;
    ti_wdata = w;
    @(negedge clk);
    ti_wr = 1'b0;
    r_le  = 1'b0;
    nclk(HOLD);
    treg_m[0] = w;
    pend_m[0] = 1'b1;
    chk("coll_pend", ti_pend, pend_m);
    tx_check("coll", old);
    rd_check("coll_treg0", 1'b1, 0);

    wr(1, W'($urandom));
    @(negedge clk);
    r_rt = 1'b0;
    for (int i = 0; i < 4; i++)
      pulse_clk(1'($urandom_range(1)));
    chk("midrx_busy", busy, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrx_rdata", ti_rdata, 0);
    chk("midrx_din", r_din, 0);
    chk("midrx_pend", ti_pend, 0);
    chk("midrx_busy0", busy, 0);
    chk("midrx_ferr", frame_err, 0);
    nclk(2);
    reset = 1'b0;
    rd_check("midrx_rreg0", 1'b0, 0);
    rd_check("midrx_treg1", 1'b1, 1);
    rx_frame(16'($urandom_range(255)), W, 0);
    rd_check("post_rst_rx", 1'b0, 0);
    chk("post_rst_ferr", frame_err, ferr_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
